reg_file_mp: RTL

Multi-port integer register file with an integrated write-pending scoreboard, for the superscalar/OoO-lite NPC core. It generalises the single-write/dual-read register file in width, depth, and read/write port count. It adds optional same-cycle write-to-read bypass and per-register busy tracking that the issue stage uses to stall on RAW hazards. It sits between decode/issue (reads, issue marks) and writeback (writes, busy clears).

---
 rtl/npc_rf_pkg.sv | 13 +
 rtl/reg_file_scoreboard.sv | 40 ++++
 rtl/reg_file_mp.sv | 110 +++++++++++
 3 files changed

// File: rtl/npc_rf_pkg.sv
// Shared definitions for the NPC multi-port register file: address width
// helper, default data width and the hardwired-zero register index.
package npc_rf_pkg;

  localparam int DEF_XLEN  = 64;
  localparam int ZERO_ADDR = 0;

  // Address width for a register file of n entries; never narrower than 1 bit.
  function automatic int rf_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register write-pending bits: issue marks a register busy, a writeback
// to it clears the bit, and a same-cycle issue wins over the clear.
module reg_file_scoreboard
  import npc_rf_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = rf_aw(NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [NREG-1:0]   busy_vec
);

  for (genvar r = 0; r < NREG; r++) begin : g_bit
    logic set_r;
    logic clr_r;

    always_comb begin
      set_r = iss_en && (iss_addr == AW'(r));
      clr_r = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) clr_r = 1'b1;
      end
    end

    // The zero register folds into the reset term so it can never go busy.
    always_ff @(posedge clock) begin
      if (reset || (ZERO_REG != 0 && r == ZERO_ADDR)) busy_vec[r] <= 1'b0;
      else if (set_r)                                 busy_vec[r] <= 1'b1;
      else if (clr_r)                                 busy_vec[r] <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional same-cycle write bypass
// and an integrated RAW scoreboard used by issue to stall on busy sources.
module reg_file_mp
  import npc_rf_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = rf_aw(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] regs [NREG];

  reg_file_scoreboard #(
    .NREG     (NREG),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec)
  );

  // Write-port priority: scanning ports in ascending order lets the highest
  // matching index overwrite earlier matches.
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    logic            we_r;
    logic [XLEN-1:0] wd_r;

    always_comb begin
      we_r = 1'b0;
      wd_r = '0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
          we_r = 1'b1;
          wd_r = wr_data[j*XLEN +: XLEN];
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset || (ZERO_REG != 0 && r == ZERO_ADDR)) regs[r] <= '0;
      else if (we_r)                                  regs[r] <= wd_r;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr_k;
    logic            in_range;
    logic            valid;
    logic [XLEN-1:0] stored;
    logic            stored_busy;
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;

    always_comb begin
      addr_k      = rd_addr[k*AW +: AW];
      in_range    = 1'b0;
      stored      = '0;
      stored_busy = 1'b0;
      for (int r = 0; r < NREG; r++) begin
        if (addr_k == AW'(r)) begin
          in_range    = 1'b1;
          stored      = regs[r];
          stored_busy = busy_vec[r];
        end
      end
      byp_hit  = 1'b0;
      byp_data = '0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == addr_k)) begin
          byp_hit  = 1'b1;
          byp_data = wr_data[j*XLEN +: XLEN];
        end
      end
      // Out-of-range and hardwired-zero addresses never see writes or busy.
      valid = in_range && !(ZERO_REG != 0 && addr_k == AW'(ZERO_ADDR));
      if (!valid) begin
        rd_data[k*XLEN +: XLEN] = '0;
        rd_busy[k]              = 1'b0;
      end else if (BYPASS != 0 && byp_hit) begin
        rd_data[k*XLEN +: XLEN] = byp_data;
        rd_busy[k]              = 1'b0;
      end else begin
        rd_data[k*XLEN +: XLEN] = stored;
        rd_busy[k]              = stored_busy;
      end
    end
  end

endmodule
